mult_div_unit: RTL and testbench

//  Iterative multiply/divide unit; sits downstream of the multicycle control FSM beside the ALU.

---
 rtl/mult_div_unit_if.sv | 25 ++
 rtl/mult_div_unit.sv | 147 ++++++++++++++
 tb/tb_mult_div_unit.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult_div_unit_if.sv
// Handshake and result bundle between the multicycle control FSM and the
// iterative multiply/divide unit.
interface mult_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b,
        input  busy, done, div_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, div_zero, hi, lo
    );
endinterface

// File: rtl/mult_div_unit.sv
// Radix-2 iterative multiply/divide unit: shift-add multiply, restoring divide.
// Results land in HI/LO, which hold until the next operation completes or reset.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    mult_div_unit_if.slave   bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t state, state_nxt;

    logic                 is_div;
    logic                 sign_a;
    logic                 sign_b;
    logic                 b_zero;
    logic [CW-1:0]        cnt;
    logic [WIDTH-1:0]     opnd;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH:0]       rem;

    logic                 busy_q;
    logic                 done_q;
    logic                 div_zero_q;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;

    logic                 accept;
    logic                 calc_last;
    logic [WIDTH-1:0]     abs_a;
    logic [WIDTH-1:0]     abs_b;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH+1:0]     div_shift;
    logic [WIDTH+1:0]     div_trial;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix;
    logic [WIDTH-1:0]     rem_fix;

    // busy/done are registered copies of the state, one cycle behind it, so
    // done_q also blocks a start in the first IDLE cycle after completion.
    assign accept    = (state == IDLE) && bus.start && !done_q;
    assign calc_last = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = CALC;
            CALC:    if (calc_last) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        abs_a = (!bus.op[1] && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        abs_b = (!bus.op[1] && bus.b[WIDTH-1]) ? -bus.b : bus.b;

        mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : '0)};

        // rem[WIDTH] stays 0 between steps, so the trial is negative exactly
        // when its top bit is set.
        div_shift = {rem, acc[WIDTH-1]};
        div_trial = div_shift - {2'b00, opnd};

        prod_fix = (sign_a ^ sign_b) ? -acc : acc;
        quo_fix  = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix  = sign_a ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            is_div     <= 1'b0;
            sign_a     <= 1'b0;
            sign_b     <= 1'b0;
            b_zero     <= 1'b0;
            cnt        <= '0;
            opnd       <= '0;
            acc        <= '0;
            rem        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
        end else begin
            busy_q <= (state == CALC) || (state == FIX);
            done_q <= (state == DONE);
            case (state)
                IDLE: begin
                    if (accept) begin
                        is_div     <= bus.op[0];
                        sign_a     <= !bus.op[1] && bus.a[WIDTH-1];
                        sign_b     <= !bus.op[1] && bus.b[WIDTH-1];
                        b_zero     <= (bus.b == '0);
                        opnd       <= bus.op[0] ? abs_b : abs_a;
                        acc        <= {{WIDTH{1'b0}}, (bus.op[0] ? abs_a : abs_b)};
                        rem        <= '0;
                        cnt        <= '0;
                        div_zero_q <= 1'b0;
                    end
                end
                CALC: begin
                    cnt <= cnt + CW'(1);
                    if (!is_div) begin
                        acc <= {mul_sum, acc[WIDTH-1:1]};
                    end else if (!div_trial[WIDTH+1]) begin
                        rem              <= div_trial[WIDTH:0];
                        acc[WIDTH-1:0]   <= {acc[WIDTH-2:0], 1'b1};
                    end else begin
                        rem              <= div_shift[WIDTH:0];
                        acc[WIDTH-1:0]   <= {acc[WIDTH-2:0], 1'b0};
                    end
                end
                FIX: begin
                    if (is_div) begin
                        // Dividing by zero leaves |a| in rem; the sign fix restores a.
                        hi_q       <= rem_fix;
                        lo_q       <= b_zero ? '1 : quo_fix;
                        div_zero_q <= b_zero;
                    end else begin
                        hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                        lo_q <= prod_fix[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.div_zero = div_zero_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases, random operations
// against an arithmetic reference model, start blocking, and mid-op reset.
module tb_mult_div_unit;
    localparam int W = 32;
    localparam int LAT = W + 2;

    logic clk = 1'b0;
    logic rst;
    int   passed = 0;
    int   total = 0;

    always #5 clk = ~clk;

    mult_div_unit_if #(.WIDTH(W)) bus();

    mult_div_unit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference: {div_zero, hi, lo} from plain arithmetic on the operands.
    function automatic logic [2*W:0] model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        longint          sx;
        longint          sy;
        longint unsigned ux;
        longint unsigned uy;
        logic [2*W-1:0]  p;
        logic [W-1:0]    q;
        logic [W-1:0]    r;
        logic            dz;
        sx = $signed(x);
        sy = $signed(y);
        ux = x;
        uy = y;
        dz = 1'b0;
        p  = '0;
        if (!o[0]) begin
            p = o[1] ? ux * uy : sx * sy;
        end else if (y == 0) begin
            p  = {x, {W{1'b1}}};
            dz = 1'b1;
        end else begin
            if (o[1]) begin
                q = W'(ux / uy);
                r = W'(ux % uy);
            end else begin
                q = W'(sx / sy);
                r = W'(sx % sy);
            end
            p = {r, q};
        end
        return {dz, p};
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          output int lat, output logic [W-1:0] rh, output logic [W-1:0] rl,
                          output logic dz, output logic dz_acc, output logic pulse_ok);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = o;
        bus.a     = x;
        bus.b     = y;
        @(posedge clk);
        #1;
        dz_acc = bus.div_zero;
        @(negedge clk);
        bus.start = 1'b0;
        bus.a     = $urandom;
        bus.b     = $urandom;
        lat = -1;
        for (int i = 1; i <= LAT + 20; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = i;
                break;
            end
        end
        rh       = bus.hi;
        rl       = bus.lo;
        dz       = bus.div_zero;
        pulse_ok = !bus.busy;
        @(posedge clk);
        #1;
        pulse_ok = pulse_ok && !bus.done;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op    = 2'b00;
        bus.a     = '0;
        bus.b     = '0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.busy); else passed++;
        total++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %b expected 0", bus.done); else passed++;
        total++; if (bus.div_zero !== 1'b0) $display("FAIL reset_div_zero: got %b expected 0", bus.div_zero); else passed++;
        total++; if (bus.hi !== '0) $display("FAIL reset_hi: got %h expected 0", bus.hi); else passed++;
        total++; if (bus.lo !== '0) $display("FAIL reset_lo: got %h expected 0", bus.lo); else passed++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_latency();
        logic busy_seen [0:LAT];
        logic done_seen [0:LAT];
        int   bad_busy;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.a     = 32'd5;
        bus.b     = 32'd6;
        for (int i = 0; i <= LAT; i++) begin
            @(posedge clk);
            #1;
            busy_seen[i] = bus.busy;
            done_seen[i] = bus.done;
            @(negedge clk);
            bus.start = 1'b0;
        end
        bad_busy = 0;
        for (int i = 1; i <= W + 1; i++) if (busy_seen[i] !== 1'b1 || done_seen[i] !== 1'b0) bad_busy++;
        total++; if (busy_seen[0] !== 1'b0) $display("FAIL lat_busy_edge0: got %b expected 0", busy_seen[0]); else passed++;
        total++; if (bad_busy != 0) $display("FAIL lat_busy_window: got %0d bad cycles expected 0", bad_busy); else passed++;
        total++; if (done_seen[LAT] !== 1'b1 || busy_seen[LAT] !== 1'b0)
            $display("FAIL lat_done_edge: got done=%b busy=%b expected done=1 busy=0", done_seen[LAT], busy_seen[LAT]); else passed++;
        total++; if (bus.lo !== 32'd30) $display("FAIL lat_result: got %h expected %h", bus.lo, 32'd30); else passed++;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_directed();
        int lat;
        logic [W-1:0] rh, rl;
        logic dz, dz_acc, pulse_ok;

        run_op(2'b00, 32'd7, 32'hFFFFFFFD, lat, rh, rl, dz, dz_acc, pulse_ok);
        total++; if (lat != LAT) $display("FAIL mul_s_latency: got %0d expected %0d", lat, LAT); else passed++;
        total++; if (rh !== 32'hFFFFFFFF || rl !== 32'hFFFFFFEB)
            $display("FAIL mul_s_7x-3: got %h_%h expected ffffffff_ffffffeb", rh, rl); else passed++;
        total++; if (!pulse_ok) $display("FAIL mul_s_pulse: got pulse_ok=%b expected 1", pulse_ok); else passed++;

        run_op(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, rh, rl, dz, dz_acc, pulse_ok);
        total++; if (rh !== 32'hFFFFFFFE || rl !== 32'h00000001)
            $display("FAIL mul_u_max: got %h_%h expected fffffffe_00000001", rh, rl); else passed++;

        run_op(2'b01, 32'hFFFFFFF9, 32'd2, lat, rh, rl, dz, dz_acc, pulse_ok);
        total++; if (rh !== 32'hFFFFFFFF || rl !== 32'hFFFFFFFD || dz !== 1'b0)
            $display("FAIL div_s_-7/2: got hi=%h lo=%h dz=%b expected ffffffff fffffffd 0", rh, rl, dz); else passed++;

        run_op(2'b11, 32'd100, 32'd0, lat, rh, rl, dz, dz_acc, pulse_ok);
        total++; if (lat != LAT) $display("FAIL div0_latency: got %0d expected %0d", lat, LAT); else passed++;
        total++; if (rh !== 32'd100 || rl !== 32'hFFFFFFFF || dz !== 1'b1)
            $display("FAIL div0_result: got hi=%h lo=%h dz=%b expected 00000064 ffffffff 1", rh, rl, dz); else passed++;

        run_op(2'b11, 32'd9, 32'd3, lat, rh, rl, dz, dz_acc, pulse_ok);
        total++; if (dz_acc !== 1'b0) $display("FAIL div0_clear_on_accept: got %b expected 0", dz_acc); else passed++;
        total++; if (rh !== 32'd0 || rl !== 32'd3 || dz !== 1'b0)
            $display("FAIL div_9/3: got hi=%h lo=%h dz=%b expected 0 3 0", rh, rl, dz); else passed++;

        run_op(2'b01, 32'h80000000, 32'hFFFFFFFF, lat, rh, rl, dz, dz_acc, pulse_ok);
        total++; if (rh !== 32'd0 || rl !== 32'h80000000)
            $display("FAIL div_s_overflow: got hi=%h lo=%h expected 0 80000000", rh, rl); else passed++;

        run_op(2'b01, 32'hFFFFFFF6, 32'd0, lat, rh, rl, dz, dz_acc, pulse_ok);
        total++; if (rh !== 32'hFFFFFFF6 || rl !== 32'hFFFFFFFF || dz !== 1'b1)
            $display("FAIL div0_signed_neg: got hi=%h lo=%h dz=%b expected fffffff6 ffffffff 1", rh, rl, dz); else passed++;
    endtask

    task automatic test_random();
        int lat;
        logic [W-1:0] rh, rl, x, y;
        logic [1:0] o;
        logic dz, dz_acc, pulse_ok;
        logic [2*W:0] exp;
        for (int n = 0; n < 40; n++) begin
            o = 2'($urandom_range(0, 3));
            x = $urandom;
            y = $urandom;
            case ($urandom_range(0, 9))
                0: y = '0;
                1: y = W'($urandom_range(1, 15));
                2: begin x = 32'h80000000; y = '1; end
                3: x = W'($urandom_range(0, 255));
                default: ;
            endcase
            exp = model(o, x, y);
            run_op(o, x, y, lat, rh, rl, dz, dz_acc, pulse_ok);
            total++; if ({rh, rl} !== exp[2*W-1:0])
                $display("FAIL rand_result op=%b a=%h b=%h: got %h_%h expected %h_%h", o, x, y, rh, rl, exp[2*W-1:W], exp[W-1:0]); else passed++;
            total++; if (dz !== exp[2*W])
                $display("FAIL rand_div_zero op=%b b=%h: got %b expected %b", o, y, dz, exp[2*W]); else passed++;
            total++; if (lat != LAT || !pulse_ok)
                $display("FAIL rand_timing op=%b: got lat=%0d pulse_ok=%b expected %0d 1", o, lat, pulse_ok, LAT); else passed++;
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] x0, y0, rh, rl;
        logic [2*W:0] exp;
        int dones;
        x0 = $urandom;
        y0 = $urandom;
        exp = model(2'b00, x0, y0);
        rh = '0;
        rl = '0;
        dones = 0;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'b00;
        bus.a     = x0;
        bus.b     = y0;
        // start stays high through the cycle where done is visible
        for (int i = 0; i <= LAT + 1; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                dones++;
                rh = bus.hi;
                rl = bus.lo;
            end
            @(negedge clk);
            bus.a  = $urandom;
            bus.b  = $urandom;
            bus.op = 2'($urandom_range(0, 3));
        end
        bus.start = 1'b0;
        for (int i = 0; i < LAT + 10; i++) begin
            @(posedge clk);
            #1;
            if (bus.done) dones++;
        end
        total++; if (dones != 1) $display("FAIL b2b_done_count: got %0d expected 1", dones); else passed++;
        total++; if ({rh, rl} !== exp[2*W-1:0])
            $display("FAIL b2b_first_result: got %h_%h expected %h_%h", rh, rl, exp[2*W-1:W], exp[W-1:0]); else passed++;
        total++; if (bus.busy !== 1'b0) $display("FAIL b2b_idle_after: got busy=%b expected 0", bus.busy); else passed++;
    endtask

    task automatic test_reset_midop();
        int lat, dones;
        logic [W-1:0] rh, rl, x, y;
        logic dz, dz_acc, pulse_ok;
        logic [2*W:0] exp;

        run_op(2'b11, 32'd55, 32'd0, lat, rh, rl, dz, dz_acc, pulse_ok);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        total++; if (bus.div_zero !== 1'b0 || bus.hi !== '0)
            $display("FAIL rst_idle_clear: got dz=%b hi=%h expected 0 0", bus.div_zero, bus.hi); else passed++;
        @(negedge clk);
        rst = 1'b0;

        run_op(2'b00, 32'd1234, 32'd5678, lat, rh, rl, dz, dz_acc, pulse_ok);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = 2'b10;
        bus.a     = 32'hDEADBEEF;
        bus.b     = 32'h12345678;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0)
            $display("FAIL rst_mid_ctrl: got busy=%b done=%b expected 0 0", bus.busy, bus.done); else passed++;
        total++; if (bus.hi !== '0 || bus.lo !== '0 || bus.div_zero !== 1'b0)
            $display("FAIL rst_mid_data: got hi=%h lo=%h dz=%b expected 0 0 0", bus.hi, bus.lo, bus.div_zero); else passed++;
        @(negedge clk);
        rst = 1'b0;
        dones = 0;
        for (int i = 0; i < LAT + 8; i++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) dones++;
        end
        total++; if (dones != 0) $display("FAIL rst_mid_no_done: got %0d active cycles expected 0", dones); else passed++;

        x = $urandom;
        y = $urandom;
        exp = model(2'b01, x, y);
        run_op(2'b01, x, y, lat, rh, rl, dz, dz_acc, pulse_ok);
        total++; if ({rh, rl} !== exp[2*W-1:0] || lat != LAT)
            $display("FAIL rst_fresh_op: got %h_%h lat=%0d expected %h_%h lat=%0d", rh, rl, lat, exp[2*W-1:W], exp[W-1:0], LAT); else passed++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_latency();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_midop();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
